// File: rtl/mdu_pkg.sv
// Shared MDU operation codes (mirrored by the controller) and counter sizing helper.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  // Busy counter must hold the longest latency; never narrower than 4 bits.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO. Results are computed at the
// accepting edge, held in pending registers, and committed when the counter expires.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  mduOp,
  input  logic        start,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mduRes
);

  localparam int CW = cnt_width((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES);

  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   phi_q, phi_d, plo_q, plo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d;

  logic [63:0] sprod, uprod;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, uq, ur, sq, sr;

  assign sprod = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
  assign uprod = {32'b0, srcA} * {32'b0, srcB};

  // Signed divide via magnitudes avoids the 0x80000000 / -1 overflow case.
  assign b_zero = (srcB == 32'd0);
  assign a_neg  = (mduOp == MDU_DIV) && srcA[31];
  assign b_neg  = (mduOp == MDU_DIV) && srcB[31];
  assign a_mag  = a_neg ? (~srcA + 32'd1) : srcA;
  assign b_mag  = b_zero ? 32'd1 : (b_neg ? (~srcB + 32'd1) : srcB);
  assign uq     = a_mag / b_mag;
  assign ur     = a_mag % b_mag;
  assign sq     = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
  assign sr     = a_neg ? (~ur + 32'd1) : ur;

  assign busy = (cnt_q != '0);

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    phi_d = phi_q;
    plo_d = plo_q;
    cnt_d = cnt_q;
    dz_d  = dz_q;
    if (busy) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1) && !dz_q) begin
        hi_d = phi_q;
        lo_d = plo_q;
      end
    end else if (start) begin
      unique case (mduOp)
        MDU_MULT: begin
          {phi_d, plo_d} = sprod;
          dz_d  = 1'b0;
          cnt_d = CW'(MULT_CYCLES);
        end
        MDU_MULTU: begin
          {phi_d, plo_d} = uprod;
          dz_d  = 1'b0;
          cnt_d = CW'(MULT_CYCLES);
        end
        MDU_DIV, MDU_DIVU: begin
          phi_d = sr;
          plo_d = sq;
          dz_d  = b_zero;
          cnt_d = CW'(DIV_CYCLES);
        end
        MDU_MTHI: hi_d = srcA;
        MDU_MTLO: lo_d = srcA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      phi_q <= '0;
      plo_q <= '0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      cnt_q <= cnt_d;
      dz_q  <= dz_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

  always_comb begin
    mduRes = 32'd0;
    if (mduOp == MDU_MFHI) mduRes = hi_q;
    else if (mduOp == MDU_MFLO) mduRes = lo_q;
  end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a 64-bit arithmetic model checked every cycle, plus
// hand-computed literal expectations for each operation and corner case.
module tb_mdu;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  mduOp = MDU_NONE;
  logic        start = 1'b0;
  logic [31:0] srcA = '0, srcB = '0;
  logic        busy;
  logic [31:0] hi, lo, mduRes;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) u_dut (
    .clk(clk), .rst_n(rst_n), .mduOp(mduOp), .start(start),
    .srcA(srcA), .srcB(srcB), .busy(busy), .hi(hi), .lo(lo), .mduRes(mduRes)
  );

  always #5 clk = ~clk;

  // Behavioural model: remaining busy cycles plus pending 64-bit arithmetic result.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_left = 0;
  bit          p_dz = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    longint a, b, q, r, pr;
    logic [63:0] up;
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; m_left = 0; p_dz = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0 && !p_dz) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (start) begin
      a = longint'($signed(srcA));
      b = longint'($signed(srcB));
      case (mduOp)
        MDU_MULT: begin
          pr = a * b; p_hi = pr[63:32]; p_lo = pr[31:0]; p_dz = 1'b0; m_left = MC;
        end
        MDU_MULTU: begin
          up = 64'(srcA) * 64'(srcB); p_hi = up[63:32]; p_lo = up[31:0]; p_dz = 1'b0; m_left = MC;
        end
        MDU_DIV, MDU_DIVU: begin
          p_dz = (srcB == 0);
          m_left = DC;
          if (!p_dz) begin
            if (mduOp == MDU_DIVU) begin
              a = longint'(srcA); b = longint'(srcB);
            end
            q = a / b; r = a % b;
            p_lo = q[31:0]; p_hi = r[31:0];
          end
        end
        MDU_MTHI: m_hi = srcA;
        MDU_MTLO: m_lo = srcA;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_res;
    if (chk_en) begin
      exp_res = (mduOp == MDU_MFHI) ? m_hi : (mduOp == MDU_MFLO) ? m_lo : 32'd0;
      tests++;
      if (busy !== (m_left > 0) || hi !== m_hi || lo !== m_lo || mduRes !== exp_res) begin
        fails++;
        $display("FAIL model t=%0t busy=%b/%b hi=%h/%h lo=%h/%h res=%h/%h (got/need)",
                 $time, busy, (m_left > 0), hi, m_hi, lo, m_lo, mduRes, exp_res);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
    tests++;
    if (got !== need) begin
      fails++;
      $display("FAIL %s got=%h need=%h", name, got, need);
    end else
      $display("[TB] ok %s = %h", name, got);
  endtask

  task automatic drive(input logic [3:0] op, input logic st, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    mduOp = op; start = st; srcA = a; srcB = b;
  endtask

  // Issue one op, return to idle inputs, and count busy cycles seen afterwards.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    drive(op, 1'b1, a, b);
    drive(MDU_NONE, 1'b0, 32'h0, 32'h0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
  endtask

  initial begin
    int n;
    #12 rst_n = 1'b1;
    @(posedge clk); #1 chk_en = 1'b1;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    run_op(MDU_MTHI, 32'h1234, 32'h0, n);
    run_op(MDU_MTLO, 32'h5678, 32'h0, n);
    check("mthi_hi", hi, 32'h1234);
    check("mtlo_lo", lo, 32'h5678);
    check("mt_nobusy", n, 0);

    run_op(MDU_MULT, 32'hFFFFFFFE, 32'd3, n);
    check("mult_busy", n, 5);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);

    run_op(MDU_MULTU, 32'hFFFFFFFE, 32'd3, n);
    check("multu_hi", hi, 32'h00000002);
    check("multu_lo", lo, 32'hFFFFFFFA);

    run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, n);
    check("div_busy", n, 10);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, n);
    check("divovf_lo", lo, 32'h80000000);
    check("divovf_hi", hi, 32'h0);

    run_op(MDU_DIVU, 32'd7, 32'd2, n);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    run_op(MDU_DIVU, 32'hFFFFFFF9, 32'd2, n);
    check("divu_big_lo", lo, 32'h7FFFFFFC);
    check("divu_big_hi", hi, 32'd1);

    run_op(MDU_MTHI, 32'h1234, 32'h0, n);
    run_op(MDU_MTLO, 32'h5678, 32'h0, n);
    run_op(MDU_DIV, 32'd99, 32'd0, n);
    check("dz_busy", n, 10);
    check("dz_hi", hi, 32'h1234);
    check("dz_lo", lo, 32'h5678);

    // MULT 6*7, then MTLO attempts and operand churn while busy.
    drive(MDU_MULT, 1'b1, 32'd6, 32'd7);
    drive(MDU_MTLO, 1'b1, 32'hDEAD, 32'hBEEF);
    drive(MDU_MULTU, 1'b1, 32'hFFFF0000, 32'h1);
    drive(MDU_MTHI, 1'b1, 32'hCAFE, 32'h5);
    drive(MDU_NONE, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    check("stall_busy_done", 32'(busy), 32'h0);
    check("stall_lo", lo, 32'd42);
    check("stall_hi", hi, 32'd0);

    drive(MDU_MFLO, 1'b1, 32'h1111, 32'h2222);
    @(negedge clk);
    check("mflo_res", mduRes, 32'd42);
    drive(MDU_MFHI, 1'b1, 32'h3333, 32'h4444);
    @(negedge clk);
    check("mfhi_res", mduRes, 32'd0);
    check("mf_lo_kept", lo, 32'd42);
    check("mf_nobusy", 32'(busy), 32'h0);
    drive(MDU_NONE, 1'b1, 32'h5555, 32'h6666);
    @(negedge clk);
    check("none_res", mduRes, 32'd0);

    run_op(MDU_MTHI, 32'hABCD, 32'h0, n);
    drive(MDU_MULT, 1'b1, 32'd100, 32'd100);
    drive(MDU_NONE, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("rst_async_busy", 32'(busy), 32'h0);
    check("rst_async_hi", hi, 32'h0);
    check("rst_async_lo", lo, 32'h0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("rst_nocommit_lo", lo, 32'h0);
    check("rst_nocommit_hi", hi, 32'h0);
    check("rst_nocommit_busy", 32'(busy), 32'h0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
